// File: rtl/derivative_row_sequencer_pkg.sv
// Shared definitions for the derivative row sequencer: FSM encodings and
// output FIFO sizing.
package deriv_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PRIME = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  function automatic logic [FIFO_PTR_W-1:0] ptr_next(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/derivative_row_sequencer_out_fifo.sv
// Small output FIFO holding {last, derivative} beats; exposes its fill count
// so the sequencer can meter input credits.
module deriv_out_fifo
  import deriv_defs::*;
#(
  parameter int W = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [W-1:0]          wdata,
  input  logic                  pop,
  output logic [W-1:0]          rdata,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [FIFO_DEPTH-1:0][W-1:0] mem;
  logic [FIFO_PTR_W-1:0]        wr_ptr, rd_ptr;
  logic                         do_push, do_pop;

  assign do_push = push && (count != FIFO_CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/derivative_row_sequencer.sv
// Row sequencer around an external derivative core: primes the core with the
// first pixel of a row, streams the remaining results through a credit-metered FIFO.
module derivative_row_sequencer
  import deriv_defs::*;
#(
  parameter int DATA_W  = 8,
  parameter int DER_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              der_clr,
  output logic              der_enb,
  output logic [DATA_W-1:0] der_in,
  input  logic [DATA_W-1:0] der_d,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  row_cnt,
  output logic              err_short
);

  state_e                state, state_nxt;
  logic                  abort_act, accept, room, pop, push;
  logic [DATA_W-1:0]     der_in_q;
  logic                  vld_in, lst_in;
  logic [DER_LAT-1:0]    vld_q, lst_q;
  logic [DER_LAT:0]      vld_pipe, lst_pipe;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_W:0]       fifo_rdata;
  int                    in_flight;

  assign abort_act = abort && (state != ST_IDLE);
  assign accept    = s_valid && s_ready;
  assign pop       = m_valid && m_ready;

  // Results still inside the core count against FIFO space, so a push can never overflow.
  always_comb begin
    in_flight = 0;
    for (int i = 0; i < DER_LAT; i++)
      if (vld_q[i]) in_flight++;
  end
  assign room = (int'(fifo_count) + in_flight) < FIFO_DEPTH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_act) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_CLEAR;
        ST_CLEAR: state_nxt = ST_PRIME;
        ST_PRIME: if (accept) state_nxt = s_last ? ST_IDLE : ST_RUN;
        ST_RUN:   if (accept && s_last) state_nxt = ST_DRAIN;
        ST_DRAIN: if (pop && m_last) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready   = 1'b0;
    case (state)
      ST_PRIME: s_ready = 1'b1;
      ST_RUN:   s_ready = room;
      default:  s_ready = 1'b0;
    endcase
    if (abort_act) s_ready = 1'b0;
    der_clr   = (state == ST_CLEAR) || abort_act;
    der_enb   = accept;
    der_in    = accept ? s_data : der_in_q;
    busy      = (state != ST_IDLE);
    err_short = (state == ST_PRIME) && accept && s_last;
    // The priming beat only seeds core history; only RUN beats yield results.
    vld_in    = (state == ST_RUN) && accept;
    lst_in    = vld_in && s_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      der_in_q <= '0;
    else if (accept) der_in_q <= s_data;
  end

  assign vld_pipe = {vld_q, vld_in};
  assign lst_pipe = {lst_q, lst_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (abort_act) begin
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= vld_pipe[DER_LAT-1:0];
      lst_q <= lst_pipe[DER_LAT-1:0];
    end
  end

  assign push = vld_pipe[DER_LAT] && !abort_act;

  deriv_out_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort_act),
    .push  (push),
    .wdata ({lst_pipe[DER_LAT], der_d}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign m_valid = (fifo_count != '0);
  assign m_last  = fifo_rdata[DATA_W];
  assign m_data  = fifo_rdata[DATA_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      row_cnt <= '0;
    else if ((state == ST_DRAIN) && !abort_act && pop && m_last)
      row_cnt <= row_cnt + 1'b1;
  end

endmodule

// File: tb/tb_derivative_row_sequencer.sv
// Directed bench for derivative_row_sequencer with a behavioral
// first-difference core (one-cycle latency) on the der_* ports.
module tb_derivative_row_sequencer;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_ready, der_clr, der_enb, m_valid, m_last, busy, err_short;
  logic [7:0]  der_in, der_d, m_data, core_prev;
  logic [15:0] row_cnt;

  int   n_chk = 0, n_fail = 0, err_cnt = 0;
  logic px_err, stall_sr, stall_mv;
  logic [7:0] got_d[$];
  logic       got_l[$];

  derivative_row_sequencer #(.DATA_W(8), .DER_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .der_clr(der_clr), .der_enb(der_enb), .der_in(der_in), .der_d(der_d),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .row_cnt(row_cnt), .err_short(err_short)
  );

  always #5 clk = ~clk;

  // External core: registered first difference against the previous pixel.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      der_d <= '0; core_prev <= '0;
    end else if (der_clr) begin
      core_prev <= '0;
    end else if (der_enb) begin
      der_d     <= der_in - core_prev;
      core_prev <= der_in;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
      end
      if (err_short) err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {25'd0, s_ready, der_clr, der_enb, m_valid, m_last, busy, err_short}, 32'd0);
    chk({tag, "_dat"}, {16'd0, der_in, m_data}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, row_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    start = 0; abort = 0; s_valid = 0; s_last = 0; m_ready = 1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    got_d.delete(); got_l.delete(); err_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic push_px(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    s_valid = 1; s_data = d; s_last = last;
    @(negedge clk);
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    px_err = err_short;
    chk("px_accept_timeout", {31'd0, t < 100}, 32'd1);
    @(posedge clk); #1 s_valid = 0; s_last = 0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin @(posedge clk); #1; t++; end
    chk("idle_timeout", {31'd0, t < 200}, 32'd1);
  endtask

  task automatic chk_beats(input string tag, input int n, input logic [7:0] val);
    chk({tag, "_count"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      chk({tag, "_data"}, {24'd0, got_d[i]}, {24'd0, val});
      chk({tag, "_last"}, {31'd0, got_l[i]}, {31'd0, (i == n - 1)});
    end
    got_d.delete(); got_l.delete();
  endtask

  initial begin
    // Reset values, asynchronously before any clock edge.
    #2 chk_reset_outs("reset");
    do_reset();

    // Row 0..4: four beats of 1, last on the fourth.
    pulse_start();
    chk("clear_ctl", {29'd0, der_clr, der_enb, busy}, 32'b101);
    for (int i = 0; i < 5; i++) push_px(8'(i), i == 4);
    wait_idle();
    chk_beats("row01234", 4, 8'd1);
    chk("row01234_cnt", {16'd0, row_cnt}, 32'd1);
    chk("row01234_err", err_cnt, 0);

    // Row step 4, then a short row 0,1,2.
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) push_px(8'(4 * i), i == 4);
    wait_idle();
    chk_beats("row_step4", 4, 8'd4);
    pulse_start();
    for (int i = 0; i < 3; i++) push_px(8'(i), i == 2);
    wait_idle();
    chk_beats("row012", 2, 8'd1);
    chk("two_rows_cnt", {16'd0, row_cnt}, 32'd2);

    // Row 0..9 with a six-cycle output stall: credits run out, nothing lost.
    do_reset();
    pulse_start();
    fork
      for (int i = 0; i < 10; i++) push_px(8'(i), i == 9);
      begin
        repeat (4) @(posedge clk);
        #1 m_ready = 0;
        repeat (6) @(negedge clk);
        stall_sr = s_ready; stall_mv = m_valid;
        @(posedge clk); #1 m_ready = 1;
      end
    join
    chk("stall_s_ready", {31'd0, stall_sr}, 32'd0);
    chk("stall_m_valid", {31'd0, stall_mv}, 32'd1);
    wait_idle();
    chk_beats("row0to9", 9, 8'd1);
    chk("row0to9_cnt", {16'd0, row_cnt}, 32'd1);

    // Single-pixel row: short-row error, no output.
    do_reset();
    pulse_start();
    push_px(8'd7, 1'b1);
    chk("short_err_pulse", {31'd0, px_err}, 32'd1);
    chk("short_idle", {30'd0, busy, err_short}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("short_err_count", err_cnt, 1);
    chk("short_no_beats", got_d.size(), 0);
    chk("short_cnt", {16'd0, row_cnt}, 32'd0);

    // Reset mid-row, then a clean two-pixel row.
    do_reset();
    pulse_start();
    push_px(8'd10, 1'b0); push_px(8'd13, 1'b0); push_px(8'd20, 1'b0);
    reset = 0;
    #2 chk_reset_outs("midrow_reset_async");
    @(negedge clk); chk_reset_outs("midrow_reset_hold");
    repeat (2) @(posedge clk);
    #1 reset = 1;
    got_d.delete(); got_l.delete();
    repeat (3) @(posedge clk); #1;
    chk("post_reset_idle", {30'd0, busy, m_valid}, 32'd0);
    pulse_start();
    push_px(8'd5, 1'b0); push_px(8'd6, 1'b1);
    wait_idle();
    chk_beats("row56", 1, 8'd1);
    chk("row56_cnt", {16'd0, row_cnt}, 32'd1);

    // Abort with a full FIFO; a start pulse while busy is ignored.
    do_reset();
    m_ready = 0;
    pulse_start();
    push_px(8'd0, 1'b0); push_px(8'd2, 1'b0); push_px(8'd4, 1'b0);
    start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("busy_start_ignored", {29'd0, der_clr, busy, m_valid}, 32'b011);
    @(posedge clk); #1 abort = 1;
    @(negedge clk);
    chk("abort_clr", {31'd0, der_clr}, 32'd1);
    @(posedge clk); #1 abort = 0; m_ready = 1;
    @(negedge clk);
    chk("abort_flushed", {29'd0, busy, m_valid, der_clr}, 32'd0);
    repeat (4) @(posedge clk); #1;
    chk("abort_no_beats", got_d.size(), 0);
    chk("abort_cnt", {16'd0, row_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
